vscale_dmem_bridge: RTL and testbench

VSCALE_DMEM_BRIDGE -- requirements
Module: vscale_dmem_bridge

---
 rtl/vscale_dmem_bridge_pkg.sv | 20 ++
 rtl/vscale_dmem_bridge_if.sv | 28 ++
 rtl/vscale_dmem_align.sv | 33 +++
 rtl/vscale_dmem_bridge.sv | 95 +++++++++
 tb/tb_vscale_dmem_bridge.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/vscale_dmem_bridge_pkg.sv
// Shared types and constants for the vscale data-memory bridge.
// Size codes match the core's MEM_TYPE encoding so the core connects without translation.
package vscale_dmem_bridge_pkg;

    localparam int unsigned MEM_TYPE_WIDTH = 3;

    localparam logic [MEM_TYPE_WIDTH-1:0] MEM_TYPE_B  = 3'd0;
    localparam logic [MEM_TYPE_WIDTH-1:0] MEM_TYPE_H  = 3'd1;
    localparam logic [MEM_TYPE_WIDTH-1:0] MEM_TYPE_W  = 3'd2;
    localparam logic [MEM_TYPE_WIDTH-1:0] MEM_TYPE_BU = 3'd4;
    localparam logic [MEM_TYPE_WIDTH-1:0] MEM_TYPE_HU = 3'd5;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StReq  = 2'd1,
        StResp = 2'd2,
        StErr  = 2'd3
    } bridge_state_e;

endpackage

// File: rtl/vscale_dmem_bridge_if.sv
// Valid/ready data bus between the bridge (master) and memory (slave).
interface vscale_dmem_bridge_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
);
    logic                  bus_req_valid;
    logic                  bus_req_ready;
    logic                  bus_req_wen;
    logic [ADDR_WIDTH-1:0] bus_req_addr;
    logic [3:0]            bus_req_wstrb;
    logic [DATA_WIDTH-1:0] bus_req_wdata;
    logic                  bus_resp_valid;
    logic                  bus_resp_ready;
    logic [DATA_WIDTH-1:0] bus_resp_rdata;
    logic                  bus_resp_err;

    modport master (
        output bus_req_valid, bus_req_wen, bus_req_addr, bus_req_wstrb, bus_req_wdata,
        output bus_resp_ready,
        input  bus_req_ready, bus_resp_valid, bus_resp_rdata, bus_resp_err
    );

    modport slave (
        input  bus_req_valid, bus_req_wen, bus_req_addr, bus_req_wstrb, bus_req_wdata,
        input  bus_resp_ready,
        output bus_req_ready, bus_resp_valid, bus_resp_rdata, bus_resp_err
    );
endinterface

// File: rtl/vscale_dmem_align.sv
// Byte-strobe generation and misalignment detection for one core access.
module vscale_dmem_align
    import vscale_dmem_bridge_pkg::*;
(
    input  logic [1:0]                addr_lo,
    input  logic [MEM_TYPE_WIDTH-1:0] size,
    output logic [3:0]                wstrb,
    output logic                      misaligned
);

    always_comb begin
        wstrb      = 4'b0000;
        misaligned = 1'b0;
        unique case (size)
            MEM_TYPE_B, MEM_TYPE_BU: begin
                wstrb = 4'b0001 << addr_lo;
            end
            MEM_TYPE_H, MEM_TYPE_HU: begin
                wstrb      = 4'b0011 << {addr_lo[1], 1'b0};
                misaligned = addr_lo[0];
            end
            MEM_TYPE_W: begin
                wstrb      = 4'b1111;
                misaligned = (addr_lo != 2'b00);
            end
            // Undefined size codes are reported as a fault rather than issued to the bus.
            default: begin
                misaligned = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/vscale_dmem_bridge.sv
// Converts the vscale core's fixed-latency dmem port into a valid/ready bus transaction,
// stalling the core in WB until the response arrives.
module vscale_dmem_bridge
    import vscale_dmem_bridge_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      dmem_en,
    input  logic                      dmem_wen,
    input  logic [MEM_TYPE_WIDTH-1:0] dmem_size,
    input  logic [ADDR_WIDTH-1:0]     dmem_addr,
    input  logic [DATA_WIDTH-1:0]     dmem_wdata_delayed,
    output logic                      dmem_wait,
    output logic [DATA_WIDTH-1:0]     dmem_rdata,
    output logic                      dmem_badmem_e,
    vscale_dmem_bridge_if.master      bus
);

    bridge_state_e         state_q, state_d;
    logic [ADDR_WIDTH-3:0] addr_q, addr_d;
    logic                  wen_q, wen_d;
    logic [3:0]            wstrb_q, wstrb_d;

    logic [3:0] wstrb;
    logic       misaligned;
    logic       accept;
    logic       resp_done;

    vscale_dmem_align u_align (
        .addr_lo    (dmem_addr[1:0]),
        .size       (dmem_size),
        .wstrb      (wstrb),
        .misaligned (misaligned)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            addr_q  <= '0;
            wen_q   <= 1'b0;
            wstrb_q <= 4'b0000;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wen_q   <= wen_d;
            wstrb_q <= wstrb_d;
        end
    end

    assign resp_done = (state_q == StResp) && bus.bus_resp_valid;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wen_d   = wen_q;
        wstrb_d = wstrb_q;
        accept  = 1'b0;
        unique case (state_q)
            StIdle:  accept = 1'b1;
            StReq:   if (bus.bus_req_ready) state_d = StResp;
            StResp:  accept = bus.bus_resp_valid;
            StErr:   accept = 1'b1;
            default: state_d = StIdle;
        endcase
        // A completing response or fault frees the slot, so the next access issues with no bubble.
        if (accept) begin
            if (!dmem_en) begin
                state_d = StIdle;
            end else if (misaligned) begin
                state_d = StErr;
            end else begin
                state_d = StReq;
                addr_d  = dmem_addr[ADDR_WIDTH-1:2];
                wen_d   = dmem_wen;
                wstrb_d = wstrb;
            end
        end
    end

    always_comb begin
        bus.bus_req_valid  = (state_q == StReq);
        bus.bus_req_wen    = wen_q;
        bus.bus_req_addr   = {addr_q, 2'b00};
        bus.bus_req_wstrb  = wstrb_q;
        bus.bus_req_wdata  = (state_q == StReq) ? dmem_wdata_delayed : '0;
        bus.bus_resp_ready = (state_q == StResp);
        dmem_wait          = (state_q == StReq) || ((state_q == StResp) && !bus.bus_resp_valid);
        dmem_rdata         = resp_done ? bus.bus_resp_rdata : '0;
        dmem_badmem_e      = (state_q == StErr) || (resp_done && bus.bus_resp_err);
    end

endmodule

// File: tb/tb_vscale_dmem_bridge.sv
// Directed bench for vscale_dmem_bridge: loads, stores, faults, back-to-back and reset.
module tb_vscale_dmem_bridge;
    import vscale_dmem_bridge_pkg::*;

    logic                      clk;
    logic                      reset_n;
    logic                      dmem_en;
    logic                      dmem_wen;
    logic [MEM_TYPE_WIDTH-1:0] dmem_size;
    logic [31:0]               dmem_addr;
    logic [31:0]               dmem_wdata_delayed;
    logic                      dmem_wait;
    logic [31:0]               dmem_rdata;
    logic                      dmem_badmem_e;

    int vectors;
    int miscompares;

    vscale_dmem_bridge_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    vscale_dmem_bridge #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk                (clk),
        .reset_n            (reset_n),
        .dmem_en            (dmem_en),
        .dmem_wen           (dmem_wen),
        .dmem_size          (dmem_size),
        .dmem_addr          (dmem_addr),
        .dmem_wdata_delayed (dmem_wdata_delayed),
        .dmem_wait          (dmem_wait),
        .dmem_rdata         (dmem_rdata),
        .dmem_badmem_e      (dmem_badmem_e),
        .bus                (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic core_req(input logic en, input logic wen, input logic [2:0] size,
                            input logic [31:0] addr);
        dmem_en   = en;
        dmem_wen  = wen;
        dmem_size = size;
        dmem_addr = addr;
    endtask

    task automatic mem_drive(input logic rdy, input logic rv, input logic [31:0] rd,
                             input logic er);
        bus.bus_req_ready  = rdy;
        bus.bus_resp_valid = rv;
        bus.bus_resp_rdata = rd;
        bus.bus_resp_err   = er;
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, ".valid"}, {31'd0, bus.bus_req_valid}, 32'd0);
        chk({tag, ".rready"}, {31'd0, bus.bus_resp_ready}, 32'd0);
        chk({tag, ".wait"}, {31'd0, dmem_wait}, 32'd0);
        chk({tag, ".bad"}, {31'd0, dmem_badmem_e}, 32'd0);
        chk({tag, ".rdata"}, dmem_rdata, 32'd0);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset_n     = 1'b0;
        core_req(1'b0, 1'b0, MEM_TYPE_W, 32'd0);
        dmem_wdata_delayed = 32'd0;
        mem_drive(1'b0, 1'b0, 32'd0, 1'b0);
        #2;
        chk_quiet("reset");

        @(negedge clk);
        reset_n = 1'b1;

        // Word load at 0x100, bus ready and response immediate.
        @(negedge clk);
        core_req(1'b1, 1'b0, MEM_TYPE_W, 32'h100);
        #1 chk("ld.idle_wait", {31'd0, dmem_wait}, 32'd0);
        @(negedge clk);
        core_req(1'b0, 1'b0, MEM_TYPE_W, 32'h0);
        mem_drive(1'b1, 1'b0, 32'd0, 1'b0);
        #1;
        chk("ld.valid", {31'd0, bus.bus_req_valid}, 32'd1);
        chk("ld.addr", bus.bus_req_addr, 32'h100);
        chk("ld.wstrb", {28'd0, bus.bus_req_wstrb}, 32'hF);
        chk("ld.wen", {31'd0, bus.bus_req_wen}, 32'd0);
        chk("ld.wait_req", {31'd0, dmem_wait}, 32'd1);
        @(negedge clk);
        mem_drive(1'b0, 1'b1, 32'hDEADBEEF, 1'b0);
        #1;
        chk("ld.rready", {31'd0, bus.bus_resp_ready}, 32'd1);
        chk("ld.wait_resp", {31'd0, dmem_wait}, 32'd0);
        chk("ld.rdata", dmem_rdata, 32'hDEADBEEF);
        chk("ld.bad", {31'd0, dmem_badmem_e}, 32'd0);
        @(negedge clk);
        mem_drive(1'b0, 1'b0, 32'h12345678, 1'b0);
        #1 chk_quiet("ld.after");

        // Byte store at 0x103, bus_req_ready held off for 3 cycles, response one cycle late.
        @(negedge clk);
        core_req(1'b1, 1'b1, MEM_TYPE_B, 32'h103);
        @(negedge clk);
        core_req(1'b0, 1'b0, MEM_TYPE_W, 32'h0);
        dmem_wdata_delayed = 32'h000000AA;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) @(negedge clk);
            mem_drive((i == 3), 1'b0, 32'd0, 1'b0);
            #1;
            chk("st.valid", {31'd0, bus.bus_req_valid}, 32'd1);
            chk("st.addr", bus.bus_req_addr, 32'h100);
            chk("st.wstrb", {28'd0, bus.bus_req_wstrb}, 32'h8);
            chk("st.wen", {31'd0, bus.bus_req_wen}, 32'd1);
            chk("st.wdata", bus.bus_req_wdata, 32'hAA);
            chk("st.wait_req", {31'd0, dmem_wait}, 32'd1);
        end
        @(negedge clk);
        mem_drive(1'b0, 1'b0, 32'd0, 1'b0);
        #1;
        chk("st.valid_drop", {31'd0, bus.bus_req_valid}, 32'd0);
        chk("st.wait5", {31'd0, dmem_wait}, 32'd1);
        @(negedge clk);
        mem_drive(1'b0, 1'b1, 32'd0, 1'b0);
        #1 chk("st.wait_done", {31'd0, dmem_wait}, 32'd0);
        @(negedge clk);
        mem_drive(1'b0, 1'b0, 32'd0, 1'b0);
        dmem_wdata_delayed = 32'd0;
        #1 chk_quiet("st.after");

        // Misaligned half load at 0x101, then an aligned half store issued in the ERR cycle.
        @(negedge clk);
        core_req(1'b1, 1'b0, MEM_TYPE_H, 32'h101);
        #1 chk("mis.wait0", {31'd0, dmem_wait}, 32'd0);
        @(negedge clk);
        core_req(1'b1, 1'b1, MEM_TYPE_H, 32'h102);
        #1;
        chk("mis.bad", {31'd0, dmem_badmem_e}, 32'd1);
        chk("mis.wait", {31'd0, dmem_wait}, 32'd0);
        chk("mis.valid", {31'd0, bus.bus_req_valid}, 32'd0);
        @(negedge clk);
        core_req(1'b0, 1'b0, MEM_TYPE_W, 32'h0);
        mem_drive(1'b1, 1'b0, 32'd0, 1'b0);
        #1;
        chk("err_b2b.bad", {31'd0, dmem_badmem_e}, 32'd0);
        chk("err_b2b.valid", {31'd0, bus.bus_req_valid}, 32'd1);
        chk("err_b2b.addr", bus.bus_req_addr, 32'h100);
        chk("err_b2b.wstrb", {28'd0, bus.bus_req_wstrb}, 32'hC);
        @(negedge clk);
        mem_drive(1'b0, 1'b1, 32'd0, 1'b0);
        @(negedge clk);
        mem_drive(1'b0, 1'b0, 32'd0, 1'b0);
        #1 chk_quiet("err_b2b.after");

        // Back-to-back loads at 0x0 then 0x4; second response carries an error.
        @(negedge clk);
        core_req(1'b1, 1'b0, MEM_TYPE_W, 32'h0);
        @(negedge clk);
        core_req(1'b0, 1'b0, MEM_TYPE_W, 32'h0);
        mem_drive(1'b1, 1'b0, 32'd0, 1'b0);
        #1 chk("b2b.addr0", bus.bus_req_addr, 32'h0);
        @(negedge clk);
        core_req(1'b1, 1'b0, MEM_TYPE_W, 32'h4);
        mem_drive(1'b0, 1'b1, 32'h11111111, 1'b0);
        #1;
        chk("b2b.rdata0", dmem_rdata, 32'h11111111);
        chk("b2b.wait0", {31'd0, dmem_wait}, 32'd0);
        @(negedge clk);
        core_req(1'b0, 1'b0, MEM_TYPE_W, 32'h0);
        mem_drive(1'b1, 1'b0, 32'd0, 1'b0);
        #1;
        chk("b2b.valid1", {31'd0, bus.bus_req_valid}, 32'd1);
        chk("b2b.addr1", bus.bus_req_addr, 32'h4);
        chk("b2b.wait1", {31'd0, dmem_wait}, 32'd1);
        @(negedge clk);
        mem_drive(1'b0, 1'b1, 32'h0, 1'b1);
        #1;
        chk("rerr.bad", {31'd0, dmem_badmem_e}, 32'd1);
        chk("rerr.wait", {31'd0, dmem_wait}, 32'd0);
        @(negedge clk);
        mem_drive(1'b0, 1'b0, 32'd0, 1'b0);
        #1 chk_quiet("rerr.after");

        // Reset mid-RESP, then a stray response after release.
        @(negedge clk);
        core_req(1'b1, 1'b0, MEM_TYPE_W, 32'h200);
        @(negedge clk);
        core_req(1'b0, 1'b0, MEM_TYPE_W, 32'h0);
        mem_drive(1'b1, 1'b0, 32'd0, 1'b0);
        @(negedge clk);
        mem_drive(1'b0, 1'b0, 32'd0, 1'b0);
        #1;
        chk("rst.rready", {31'd0, bus.bus_resp_ready}, 32'd1);
        chk("rst.wait_resp", {31'd0, dmem_wait}, 32'd1);
        #1 reset_n = 1'b0;
        #1 chk_quiet("rst.during");
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        mem_drive(1'b0, 1'b1, 32'hCAFEBABE, 1'b1);
        #1 chk_quiet("rst.stray");
        @(negedge clk);
        mem_drive(1'b0, 1'b0, 32'd0, 1'b0);
        #1 chk_quiet("rst.idle");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
